fifo_uart_tx: RTL

Read-side drain stage for the asynchronous FIFO. It runs in the FIFO read clock domain, pops one word at a time through the FIFO's `ren`/`rd`/`valid`/`empty` port, and serialises each word onto a UART line. Frames are start bit, LSB-first data, optional parity, then 1 or 2 stop bits. It is the consumer that turns buffered write-domain data into a bit stream.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-drain UART transmitter.
//   state_e   : transmitter FSM states
//   PAR_*     : parity mode encodings for the PARITY parameter
//   cnt_width : bit width of a counter covering 0..n-1 (min 1)
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAR   = 3'd5,
    ST_STOP  = 3'd6
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // $clog2(n), kept at least 1 bit so a counter never collapses to zero width
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_restart : force the count back to 0 on the next edge
//   o_tick    : high while the count sits at CLKS_PER_BIT-1 (last cycle of a bit)
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // next count: wrap on the last cycle of a bit or on restart
  always_comb begin
    w_cnt_nxt = r_cnt + CW'(1);
    if (i_restart || (r_cnt == LAST)) begin
      w_cnt_nxt = '0;
    end
  end

  // tick is registered from the next count so it tracks r_cnt == LAST
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      o_tick <= (w_cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pops one word at a time and sends it as a UART frame
// (start, LSB-first data, optional parity, 1 or 2 stop bits).
//   rclk, rst        : FIFO read clock, synchronous active-high reset
//   tx_en            : allows new fetches; a frame in progress always completes
//   empty, valid, rd : FIFO status, read-valid (one cycle after ren), read data
//   ren              : one-cycle read pulse per fetch
//   txd              : registered serial line, idles high
//   busy             : high whenever the FSM is not idle
//   frame_done       : one-cycle pulse in the idle cycle after the last stop bit
//   miss             : sticky, set when a fetch came back with valid low
//   tx_count         : frames sent, wraps at 16 bits
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             empty,
  input  logic             valid,
  input  logic [WIDTH-1:0] rd,
  output logic             ren,
  output logic             txd,
  output logic             busy,
  output logic             frame_done,
  output logic             miss,
  output logic [15:0]      tx_count
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam int unsigned SW = cnt_width(STOP_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);
  localparam logic ODD_PAR = (PARITY == PAR_ODD);

  state_e           r_state, w_state_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic [BW-1:0]    r_bit_idx, w_bit_idx_nxt;
  logic [SW-1:0]    r_stop_idx, w_stop_idx_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_ren, w_ren_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_miss, w_miss_nxt;
  logic [15:0]      r_count, w_count_nxt;

  // bit timing restarts while waiting for data so START gets a full period
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_clk    (rclk),
    .i_rst    (rst),
    .i_restart(r_state == ST_WAIT),
    .o_tick   (w_tick)
  );

  // state register
  always_ff @(posedge rclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (tx_en && !empty) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = valid ? ST_START : ST_IDLE;
      ST_START: if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_tick && (r_bit_idx == LAST_BIT))
                  w_state_nxt = HAS_PAR ? ST_PAR : ST_STOP;
      ST_PAR:   if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_tick && (r_stop_idx == LAST_STOP)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // output / datapath next values; txd is loaded one cycle ahead of each bit
  always_comb begin
    w_txd_nxt      = r_txd;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_miss_nxt     = r_miss;
    w_count_nxt    = r_count;
    w_done_nxt     = 1'b0;
    w_ren_nxt      = (w_state_nxt == ST_FETCH);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    case (r_state)
      ST_WAIT: begin
        if (valid) begin
          w_shift_nxt = rd;
          w_par_nxt   = (^rd) ^ ODD_PAR;
          w_txd_nxt   = 1'b0;
        end else begin
          w_miss_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_txd_nxt      = HAS_PAR ? r_par : 1'b1;
            w_stop_idx_nxt = '0;
          end else begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_idx_nxt = r_bit_idx + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_txd_nxt      = 1'b1;
          w_stop_idx_nxt = '0;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == LAST_STOP) begin
            w_done_nxt  = 1'b1;
            w_count_nxt = r_count + 16'd1;
          end else begin
            w_stop_idx_nxt = r_stop_idx + SW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // output and datapath registers
  always_ff @(posedge rclk) begin
    if (rst) begin
      r_txd      <= 1'b1;
      r_ren      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_miss     <= 1'b0;
      r_count    <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
    end else begin
      r_txd      <= w_txd_nxt;
      r_ren      <= w_ren_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_miss     <= w_miss_nxt;
      r_count    <= w_count_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
    end
  end

  assign ren        = r_ren;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign miss       = r_miss;
  assign tx_count   = r_count;

endmodule
